tlul_host_driver: RTL and testbench

Single-outstanding TL-UL host (initiator) that turns a simple valid/ready read/write command stream into TL-UL A-channel requests. It collects the matching D-channel response and returns it on a valid/ready response port. It sits between fuzzer- or testbench-generated stimulus and a DUT's TL-UL device port, driving `tl_h2d_t` and consuming `tl_d2h_t`. A cycle timeout guarantees forward progress against hung devices.

---
 rtl/tlul_host_driver.sv | 224 ++++++++++++++++++++++
 tb/tb_tlul_host_driver.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_host_driver.sv
// Single-outstanding TL-UL host: turns a valid/ready read/write command stream into
// A-channel requests and returns the matching D-channel beat (or a timeout) as a response.

package tlul_pkg;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic [15:0] a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic [15:0] d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] Get            = 3'd4;
  localparam logic [2:0] AccessAck      = 3'd0;
  localparam logic [2:0] AccessAckData  = 3'd1;

endpackage

// state | meaning
// IDLE  | ready for a command, D beats here are stale
// AREQ  | A request presented, waiting for a_ready
// DWAIT | request accepted, waiting for the D beat carrying our source
// RSP   | response presented on the rsp port, D channel back-pressured
module tlul_host_driver
  import tlul_pkg::*;
#(
  parameter int unsigned TimeoutCycles = 1024,
  parameter logic [15:0] AUser         = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_write_i,
  input  logic [31:0] cmd_addr_i,
  input  logic [31:0] cmd_wdata_i,
  input  logic [3:0]  cmd_mask_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_error_o,
  output logic        rsp_timeout_o,
  output logic [7:0]  stale_cnt_o,
  output tl_h2d_t     tl_o,
  input  tl_d2h_t     tl_i
);

  // One spare bit so the counter can step past the terminal value when a_ready
  // and terminal count coincide in AREQ.
  localparam int unsigned CntW = $clog2(TimeoutCycles) + 1;
  localparam logic [CntW-1:0] TcVal = CntW'(TimeoutCycles - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    AREQ  = 2'd1,
    DWAIT = 2'd2,
    RSP   = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic        write_q;
  logic [2:0]  opcode_q;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  mask_q;
  logic [7:0]  src_q;
  logic [7:0]  cur_src_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]  stale_q;
  logic [31:0] rdata_q;
  logic        error_q;
  logic        timeout_q;

  logic a_valid, d_ready, accept, a_hs, match, timeout, stale_beat, tc;

  assign tc = (cnt_q >= TcVal);

  always_comb begin
    state_d    = state_q;
    a_valid    = 1'b0;
    d_ready    = 1'b1;
    accept     = 1'b0;
    a_hs       = 1'b0;
    match      = 1'b0;
    timeout    = 1'b0;
    stale_beat = 1'b0;
    case (state_q)
      IDLE: begin
        stale_beat = tl_i.d_valid;
        if (cmd_valid_i) begin
          accept  = 1'b1;
          state_d = AREQ;
        end
      end
      AREQ: begin
        a_valid    = 1'b1;
        stale_beat = tl_i.d_valid;
        if (tl_i.a_ready) begin
          a_hs    = 1'b1;
          state_d = DWAIT;
        end else if (tc) begin
          timeout = 1'b1;
          state_d = RSP;
        end
      end
      DWAIT: begin
        match      = tl_i.d_valid && (tl_i.d_source == cur_src_q);
        stale_beat = tl_i.d_valid && !match;
        if (match) begin
          state_d = RSP;
        end else if (tc) begin
          timeout = 1'b1;
          state_d = RSP;
        end
      end
      RSP: begin
        d_ready = 1'b0;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      write_q   <= 1'b0;
      opcode_q  <= 3'd0;
      addr_q    <= 32'd0;
      data_q    <= 32'd0;
      mask_q    <= 4'd0;
      src_q     <= 8'd0;
      cur_src_q <= 8'd0;
      cnt_q     <= '0;
      stale_q   <= 8'd0;
      rdata_q   <= 32'd0;
      error_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        write_q <= cmd_write_i;
        addr_q  <= {cmd_addr_i[31:2], 2'b00};
        cnt_q   <= '0;
        if (cmd_write_i) begin
          opcode_q <= (cmd_mask_i == 4'hF) ? PutFullData : PutPartialData;
          mask_q   <= cmd_mask_i;
          data_q   <= cmd_wdata_i;
        end else begin
          opcode_q <= Get;
          mask_q   <= 4'hF;
          data_q   <= 32'd0;
        end
      end else if (state_q == AREQ || state_q == DWAIT) begin
        cnt_q <= cnt_q + CntW'(1);
      end

      // A timeout in AREQ still burns the source so a late beat can never alias.
      if (a_hs || (timeout && state_q == AREQ)) src_q <= src_q + 8'd1;
      if (a_hs) cur_src_q <= src_q;

      if (match) begin
        rdata_q   <= write_q ? 32'd0 : tl_i.d_data;
        error_q   <= tl_i.d_error |
                     (tl_i.d_opcode != (write_q ? AccessAck : AccessAckData));
        timeout_q <= 1'b0;
      end else if (timeout) begin
        rdata_q   <= 32'd0;
        error_q   <= 1'b1;
        timeout_q <= 1'b1;
      end

      if (stale_beat && stale_q != 8'hFF) stale_q <= stale_q + 8'd1;
    end
  end

  assign cmd_ready_o   = (state_q == IDLE);
  assign rsp_valid_o   = (state_q == RSP);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_error_o   = error_q;
  assign rsp_timeout_o = timeout_q;
  assign stale_cnt_o   = stale_q;

  always_comb begin
    tl_o           = '0;
    tl_o.a_valid   = a_valid;
    tl_o.a_opcode  = opcode_q;
    tl_o.a_param   = 3'd0;
    tl_o.a_size    = 2'd2;
    tl_o.a_source  = src_q;
    tl_o.a_address = addr_q;
    tl_o.a_mask    = mask_q;
    tl_o.a_data    = data_q;
    tl_o.a_user    = AUser;
    tl_o.d_ready   = d_ready;
  end

  logic unused_tl;
  assign unused_tl = ^{tl_i.d_param, tl_i.d_size, tl_i.d_sink, tl_i.d_user};

endmodule

// File: tb/tb_tlul_host_driver.sv
// Directed bench for tlul_host_driver: reads, writes, source matching, timeouts,
// source wrap, response back-pressure and mid-transaction reset.

module tb_tlul_host_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_mask;
  logic        rsp_valid, rsp_ready, rsp_error, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [7:0]  stale_cnt;
  logic [101:0] h2d;
  logic [67:0]  d2h;

  logic        d_valid, d_err, a_rdy;
  logic [2:0]  d_op;
  logic [7:0]  d_src;
  logic [31:0] d_data;

  // Device-side bus built directly from the documented bit positions.
  assign d2h = {d_valid, d_op, 5'b0, d_src, 1'b0, d_data, 16'b0, d_err, a_rdy};

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0;
  int n;

  localparam logic [101:0] ResetVec =
    {1'b0, 3'd0, 3'd0, 2'd2, 8'd0, 32'd0, 4'd0, 32'd0, 16'hBEEF, 1'b1};

  always #5 clk = ~clk;

  tlul_host_driver #(.TimeoutCycles(16), .AUser(16'hBEEF)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
    .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_mask_i(cmd_mask),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
    .rsp_error_o(rsp_error), .rsp_timeout_o(rsp_timeout), .stale_cnt_o(stale_cnt),
    .tl_o(h2d), .tl_i(d2h)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m);
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_mask = m;
    check("cmd_ready_idle", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic a_accept();
    a_rdy = 1'b1;
    step();
    a_rdy = 1'b0;
  endtask

  task automatic d_beat(input logic [2:0] op, input logic [7:0] src, input logic [31:0] data,
                        input logic err);
    d_valid = 1'b1; d_op = op; d_src = src; d_data = data; d_err = err;
    step();
    d_valid = 1'b0; d_err = 1'b0;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rsp_dropped", rsp_valid, 1'b0);
  endtask

  task automatic wait_rsp(input int limit);
    n = 0;
    while (!rsp_valid && n < limit) begin
      step();
      n++;
    end
    check("rsp_wait_bound", rsp_valid, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_mask = '0; rsp_ready = 1'b0; d_valid = 1'b0; d_err = 1'b0; a_rdy = 1'b0;
    d_op = '0; d_src = '0; d_data = '0;
    step(); step();
    check("reset_tl_o", h2d, ResetVec);
    check("reset_cmd_ready", cmd_ready, 1'b1);
    check("reset_rsp", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata}, 35'd0);
    check("reset_stale", stale_cnt, 8'd0);
    rst = 1'b0;
    step();

    // Read, a_ready on the third AREQ cycle, D beat the cycle after.
    t0 = cyc;
    issue(1'b0, 32'h0000_1004, 32'hFFFF_FFFF, 4'h3);
    check("rd_a_valid", h2d[101], 1'b1);
    check("rd_opcode", h2d[100:98], 3'd4);
    check("rd_param_size", h2d[97:93], {3'd0, 2'd2});
    check("rd_source", h2d[92:85], 8'd0);
    check("rd_addr", h2d[84:53], 32'h0000_1004);
    check("rd_mask", h2d[52:49], 4'hF);
    check("rd_data", h2d[48:17], 32'd0);
    step(); step();
    a_accept();
    check("rd_dwait_a_valid", h2d[101], 1'b0);
    d_beat(3'd1, 8'd0, 32'hDEAD_BEEF, 1'b0);
    check("rd_latency", cyc - t0, 5);
    check("rd_rsp_valid", rsp_valid, 1'b1);
    check("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
    check("rd_err_to", {rsp_error, rsp_timeout}, 2'b00);
    check("rsp_d_ready", h2d[0], 1'b0);
    check("rsp_cmd_ready", cmd_ready, 1'b0);
    consume();

    // Partial then full write; sources 0 and 1 after reset.
    do_reset();
    issue(1'b1, 32'h0000_2003, 32'h0000_A5A5, 4'b0011);
    check("wrp_opcode", h2d[100:98], 3'd1);
    check("wrp_addr", h2d[84:53], 32'h0000_2000);
    check("wrp_source", h2d[92:85], 8'd0);
    check("wrp_mask", h2d[52:49], 4'b0011);
    check("wrp_data", h2d[48:17], 32'h0000_A5A5);
    a_accept();
    d_beat(3'd0, 8'd0, 32'h1234_5678, 1'b0);
    check("wrp_rsp", {rsp_valid, rsp_error, rsp_timeout}, 3'b100);
    check("wrp_rdata", rsp_rdata, 32'd0);
    consume();
    issue(1'b1, 32'h0000_2008, 32'h1122_3344, 4'hF);
    check("wrf_opcode", h2d[100:98], 3'd0);
    check("wrf_source", h2d[92:85], 8'd1);
    a_accept();
    d_beat(3'd0, 8'd1, 32'd0, 1'b0);
    check("wrf_rsp", {rsp_valid, rsp_error, rsp_timeout}, 3'b100);
    consume();

    // Wrong source dropped, right source with wrong opcode flagged.
    issue(1'b0, 32'h0000_3000, 32'd0, 4'h0);
    check("ms_source", h2d[92:85], 8'd2);
    a_accept();
    d_beat(3'd1, 8'd7, 32'h5555_5555, 1'b0);
    check("ms_no_rsp", rsp_valid, 1'b0);
    check("ms_stale", stale_cnt, 8'd1);
    d_beat(3'd0, 8'd2, 32'hCAFE_0001, 1'b0);
    check("ms_rsp", {rsp_valid, rsp_error, rsp_timeout}, 3'b110);
    check("ms_rdata", rsp_rdata, 32'hCAFE_0001);
    check("ms_stale_hold", stale_cnt, 8'd1);
    consume();

    // d_error on a read.
    issue(1'b0, 32'h0000_3100, 32'd0, 4'h0);
    a_accept();
    d_beat(3'd1, 8'd3, 32'h0000_0042, 1'b1);
    check("derr_rsp", {rsp_valid, rsp_error, rsp_timeout}, 3'b110);
    consume();

    // Timeout in DWAIT, then the late beat counts as stale.
    issue(1'b0, 32'h0000_4000, 32'd0, 4'h0);
    check("to_source", h2d[92:85], 8'd4);
    t0 = cyc;
    a_accept();
    wait_rsp(40);
    check("to_latency", cyc - t0, 16);
    check("to_flags", {rsp_error, rsp_timeout}, 2'b11);
    check("to_rdata", rsp_rdata, 32'd0);
    consume();
    d_beat(3'd1, 8'd4, 32'h0BAD_0BAD, 1'b0);
    check("to_late_stale", stale_cnt, 8'd2);

    // Timeout in AREQ consumes the source.
    issue(1'b0, 32'h0000_5000, 32'd0, 4'h0);
    check("ato_source", h2d[92:85], 8'd5);
    t0 = cyc;
    wait_rsp(40);
    check("ato_latency", cyc - t0, 16);
    check("ato_a_valid", h2d[101], 1'b0);
    check("ato_flags", {rsp_error, rsp_timeout}, 2'b11);
    consume();
    issue(1'b1, 32'h0000_5004, 32'h0000_0001, 4'h1);
    check("ato_next_source", h2d[92:85], 8'd6);
    a_accept();
    d_beat(3'd0, 8'd6, 32'd0, 1'b0);
    check("ato_next_rsp", {rsp_valid, rsp_error, rsp_timeout}, 3'b100);
    consume();

    // 257 writes from reset: source walks 0..255 then wraps to 0.
    do_reset();
    for (int i = 0; i < 257; i++) begin
      issue(1'b1, i * 4, i, 4'hF);
      check("wrap_source", h2d[92:85], i[7:0]);
      a_accept();
      d_beat(3'd0, i[7:0], 32'd0, 1'b0);
      check("wrap_rsp", {rsp_valid, rsp_error}, 2'b10);
      consume();
    end

    // Response held under back-pressure; D beats there are not accepted.
    issue(1'b0, 32'h0000_6000, 32'd0, 4'h0);
    check("hold_source", h2d[92:85], 8'd1);
    a_accept();
    d_beat(3'd1, 8'd1, 32'h0BAD_F00D, 1'b0);
    cmd_valid = 1'b1; cmd_write = 1'b1; d_valid = 1'b1; d_src = 8'd9;
    for (int i = 0; i < 10; i++) begin
      check("hold_valid", rsp_valid, 1'b1);
      check("hold_rdata", rsp_rdata, 32'h0BAD_F00D);
      check("hold_d_ready", h2d[0], 1'b0);
      check("hold_cmd_ready", cmd_ready, 1'b0);
      step();
    end
    cmd_valid = 1'b0; d_valid = 1'b0;
    check("hold_stale", stale_cnt, 8'd0);
    consume();

    // Reset during DWAIT abandons the transaction.
    issue(1'b0, 32'h0000_7000, 32'd0, 4'h0);
    check("rst_source", h2d[92:85], 8'd2);
    a_accept();
    do_reset();
    check("rst_tl_o", h2d, ResetVec);
    check("rst_rsp", {rsp_valid, rsp_error, rsp_timeout, rsp_rdata}, 35'd0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    check("rst_stale", stale_cnt, 8'd0);
    step();
    check("rst_no_rsp", rsp_valid, 1'b0);
    d_beat(3'd1, 8'd2, 32'h7777_7777, 1'b0);
    check("rst_late_stale", stale_cnt, 8'd1);
    check("rst_late_no_rsp", rsp_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
